v_shift_in_4: RTL and testbench
===============================

Name: v_shift_in_4

Overview:
Serial-to-parallel front end that feeds the 4-bit clock-enabled data register. It collects framed serial bits and checks an optional parity bit. On a good frame it presents the parallel word on D_OUT together with a one-cycle CE_OUT strobe, which wire directly to the register's D and CE inputs. Bad frames are dropped, flagged and counted.

Parameters:
WIDTH, 4, data bits per frame (2..16).
MSB_FIRST, 1, 1 = first received bit lands in D_OUT[WIDTH-1]; 0 = first bit lands in D_OUT[0].
PARITY_EN, 1, 1 = one parity bit follows the data bits; 0 = no parity phase.
PARITY_ODD, 0, 0 = even parity (XOR of data and parity bits = 0 is good); 1 = odd parity.

Ports:
C  input  1  clock, rising edge.
CLRN  input  1  asynchronous, active-low reset.
SI  input  1  serial data bit.
SE  input  1  serial enable; SI is sampled only on rising C with SE=1.
SOF  input  1  start of frame; qualified by SE, marks the current SI as data bit 0.
D_OUT  output  WIDTH  last good word; connects to the downstream register's D.
CE_OUT  output  1  one-cycle load strobe; connects to the downstream register's CE.
PERR  output  1  one-cycle pulse on parity failure.
FERR  output  1  one-cycle pulse on framing error (SOF inside a frame).
BUSY  output  1  high while a frame is in progress.
ERRCNT  output  8  saturating count of PERR and FERR events.

Behaviour:
- Reset (CLRN=0, asynchronous): D_OUT=0, CE_OUT=0, PERR=0, FERR=0, BUSY=0, ERRCNT=0, shift register=0, bit count=0, state=IDLE. Any partial frame is discarded; nothing is emitted on release.
- States: IDLE, DATA, PAR.
- IDLE:
  - SE&SOF: capture SI as bit 0 and set count=1.
  - If WIDTH=1, go to PAR (PARITY_EN=1) or emit (PARITY_EN=0); otherwise go to DATA.
  - SE without SOF: bit is ignored.
- DATA:
  - SE&!SOF: shift SI in and increment count.
  - When count reaches WIDTH: go to PAR if PARITY_EN=1, else emit and return to IDLE.
- PAR:
  - SE&!SOF: compute parity over the data and SI.
  - Good parity: emit. Bad parity: pulse PERR, increment ERRCNT, leave D_OUT unchanged. Either way, return to IDLE.
- SE=0 in any state: hold state, count and shift register.
- SE&SOF in DATA or PAR:
  - Abort the current frame, pulse FERR and increment ERRCNT.
  - Restart with SI as bit 0 (count=1, state DATA). For WIDTH=1 the state is PAR, or an emit if PARITY_EN=0.
  - Nothing is emitted for the aborted frame.
- Emit:
  - D_OUT is updated and CE_OUT=1 for exactly the one cycle after the rising edge that sampled the last bit (data bit, or parity bit when PARITY_EN=1).
  - Latency from the last bit's sampling edge to CE_OUT high is 1 clock.
  - D_OUT holds its value until the next good frame.
- Back-to-back frames: in the CE_OUT cycle the FSM is already in IDLE and accepts SE&SOF, so there are zero idle cycles between frames.
- BUSY=1 in DATA and PAR, 0 in IDLE. It is registered and tracks the state.
- ERRCNT saturates at 255. PERR and FERR can never fire in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared header (include file) holds the state encodings (IDLE=2'd0, DATA=2'd1, PAR=2'd2) and the ERRCNT width localparam.
- One sub-module is natural: v_sat_counter, an 8-bit saturating up-counter with async active-low clear and an increment-enable input, instantiated for ERRCNT.
- The FSM, shifter and parity logic stay flat in v_shift_in_4.

Test Plan:
1. WIDTH=4, MSB_FIRST=1, even parity; SE=1 every cycle, bits 1,0,1,1 (SOF on first), parity 1 -> D_OUT=4'b1011, CE_OUT high for one cycle, 1 clock after the parity edge; PERR=0, ERRCNT=0.
2. Same frame with parity bit 0 -> PERR one-cycle pulse, CE_OUT stays 0, D_OUT keeps previous value, ERRCNT=1.
3. Bits 0,1,1,0 with SE=0 gaps of 3 cycles between bits, parity 0 -> D_OUT=4'b0110 after the final SE edge; BUSY=1 throughout the gaps.
4. SOF reasserted after 2 data bits, then a full frame 1,1,1,1 with parity 0 -> FERR pulse on the SOF edge, ERRCNT increments by 1, then CE_OUT with D_OUT=4'b1111.
5. CLRN pulsed low mid-frame (after 3 bits), asynchronously between clock edges -> all outputs are 0 immediately; the next full frame 0,0,0,1 with parity 1 yields D_OUT=4'b0001.
6. 300 consecutive bad-parity frames, back-to-back, then one good frame -> ERRCNT stops at 255, and the good frame's CE_OUT occurs with zero idle cycles between frames.

Source files
------------

// File: rtl/v_shift_in_4_pkg.sv
// v_shift_in_4_pkg: shared state encodings and error counter width
package v_shift_in_4_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2
  } state_e;
  localparam int ERRCNT_W = 8;
endpackage

// File: rtl/v_shift_in_4_sat_counter.sv
// v_sat_counter: saturating up-counter with async active-low clear
module v_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // Increment only below the all-ones ceiling so the count sticks at max
  always_comb cnt_d = (inc_i && cnt_q != {W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
  // Count register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/v_shift_in_4.sv
// v_shift_in_4: framed serial-to-parallel loader with parity check and error counting
module v_shift_in_4
  import v_shift_in_4_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                C,
  input  logic                CLRN,
  input  logic                SI,
  input  logic                SE,
  input  logic                SOF,
  output logic [WIDTH-1:0]    D_OUT,
  output logic                CE_OUT,
  output logic                PERR,
  output logic                FERR,
  output logic                BUSY,
  output logic [ERRCNT_W-1:0] ERRCNT
);
  localparam int CW = $clog2(WIDTH + 1);
  state_e           st_q, st_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0] sh_q, sh_d, sh_first, sh_in, dout_q, dout_d;
  logic             emit, perr, ferr, par_ok;
  logic             ce_q, perr_q, ferr_q, busy_q;
  // SI placed where the first bit must end up after WIDTH shifts; also the new-bit term of a shift
  assign sh_first = (MSB_FIRST != 0) ? WIDTH'(SI) : WIDTH'(SI) << (WIDTH - 1);
  assign sh_in    = ((MSB_FIRST != 0) ? sh_q << 1 : sh_q >> 1) | sh_first;
  assign cnt_inc  = cnt_q + 1'b1;
  assign par_ok   = ((^sh_q) ^ SI) == (PARITY_ODD != 0);
  // Next-state: frame sequencing, shifting, parity decision and event pulses
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    dout_d = dout_q;
    emit   = 1'b0;
    perr   = 1'b0;
    ferr   = 1'b0;
    if (SE && SOF) begin
      ferr  = (st_q != ST_IDLE);
      sh_d  = sh_first;
      cnt_d = CW'(1);
      if (WIDTH == 1) begin
        if (PARITY_EN != 0) st_d = ST_PAR;
        else begin
          st_d   = ST_IDLE;
          cnt_d  = '0;
          emit   = 1'b1;
          dout_d = sh_first;
        end
      end else st_d = ST_DATA;
    end else if (SE) begin
      case (st_q)
        ST_DATA: begin
          sh_d  = sh_in;
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(WIDTH)) begin
            if (PARITY_EN != 0) st_d = ST_PAR;
            else begin
              st_d   = ST_IDLE;
              cnt_d  = '0;
              emit   = 1'b1;
              dout_d = sh_in;
            end
          end
        end
        ST_PAR: begin
          st_d   = ST_IDLE;
          cnt_d  = '0;
          emit   = par_ok;
          perr   = !par_ok;
          dout_d = par_ok ? sh_q : dout_q;
        end
        default: ;
      endcase
    end
  end
  // State, datapath and registered outputs; async clear discards any partial frame
  always_ff @(posedge C or negedge CLRN)
    if (!CLRN) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      sh_q   <= '0;
      dout_q <= '0;
      ce_q   <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      dout_q <= dout_d;
      ce_q   <= emit;
      perr_q <= perr;
      ferr_q <= ferr;
      busy_q <= (st_d != ST_IDLE);
    end
  v_sat_counter #(.W(ERRCNT_W)) u_errcnt (
    .clk_i (C),
    .rst_ni(CLRN),
    .inc_i (perr | ferr),
    .cnt_o (ERRCNT)
  );
  assign D_OUT  = dout_q;
  assign CE_OUT = ce_q;
  assign PERR   = perr_q;
  assign FERR   = ferr_q;
  assign BUSY   = busy_q;
endmodule

// File: tb/tb_v_shift_in_4.sv
// tb_v_shift_in_4: scoreboard bench for the serial loader
module tb_v_shift_in_4;
  logic C = 1'b0, CLRN = 1'b0, SI = 1'b0, SE = 1'b0, SOF = 1'b0;
  logic [3:0] D_OUT;
  logic       CE_OUT, PERR, FERR, BUSY;
  logic [7:0] ERRCNT;
  int total = 0, bad = 0, cyc = 0;
  logic [7:0] err_m = '0;
  logic [3:0] last_m = '0;
  typedef struct {
    logic [2:0] ev;
    logic [3:0] d;
    logic [7:0] e;
    int         c;
  } ev_t;
  ev_t sb[$];
  v_shift_in_4 dut (
    .C(C), .CLRN(CLRN), .SI(SI), .SE(SE), .SOF(SOF),
    .D_OUT(D_OUT), .CE_OUT(CE_OUT), .PERR(PERR), .FERR(FERR),
    .BUSY(BUSY), .ERRCNT(ERRCNT)
  );
  always #5 C = ~C;
  always @(posedge C) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge C);
    #1;
  endtask
  task automatic send(input logic se, input logic si, input logic sof);
    SE = se; SI = si; SOF = sof;
    tick();
  endtask
  task automatic push(input logic [2:0] ev, input logic [3:0] d, input logic [7:0] e);
    ev_t x;
    x.ev = ev; x.d = d; x.e = e; x.c = cyc + 1;
    sb.push_back(x);
  endtask
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction
  task automatic frame(input logic [3:0] w, input logic p, input int gap, input bit busy_chk);
    for (int i = 3; i >= 0; i--) begin
      send(1'b1, w[i], i == 3);
      for (int g = 0; g < gap; g++) begin
        send(1'b0, 1'b0, 1'b0);
        if (busy_chk) chk("busy_gap", 32'(BUSY), 32'd1);
      end
    end
    if (((^w) ^ p) == 1'b0) begin
      last_m = w;
      push(3'b100, w, err_m);
    end else begin
      err_m = sat_inc(err_m);
      push(3'b010, last_m, err_m);
    end
    send(1'b1, p, 1'b0);
    SE = 1'b0;
  endtask
  // Monitor: every CE/PERR/FERR cycle must match the oldest expected event exactly
  always @(negedge C) begin
    if (CLRN && (CE_OUT || PERR || FERR)) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_event: got ce/perr/ferr=%b%b%b expected none", CE_OUT, PERR, FERR);
      end else begin
        ev_t x;
        x = sb.pop_front();
        chk("event_kind", 32'({CE_OUT, PERR, FERR}), 32'(x.ev));
        chk("event_cycle", 32'(cyc), 32'(x.c));
        chk("d_out", 32'(D_OUT), 32'(x.d));
        chk("errcnt", 32'(ERRCNT), 32'(x.e));
      end
    end
  end
  initial begin
    repeat (2) @(posedge C);
    #1;
    chk("rst_dout", 32'(D_OUT), 32'd0);
    chk("rst_flags", 32'({CE_OUT, PERR, FERR, BUSY}), 32'd0);
    chk("rst_errcnt", 32'(ERRCNT), 32'd0);
    CLRN = 1'b1;
    tick();
    frame(4'b1011, 1'b1, 0, 1'b0);
    frame(4'b1011, 1'b0, 0, 1'b0);
    frame(4'b0110, 1'b0, 3, 1'b1);
    send(1'b1, 1'b1, 1'b1);
    send(1'b1, 1'b0, 1'b0);
    err_m = sat_inc(err_m);
    push(3'b001, last_m, err_m);
    frame(4'b1111, 1'b0, 0, 1'b0);
    tick();
    chk("busy_idle", 32'(BUSY), 32'd0);
    send(1'b1, 1'b1, 1'b1);
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    SE = 1'b0;
    #2 CLRN = 1'b0;
    #1;
    chk("arst_dout", 32'(D_OUT), 32'd0);
    chk("arst_flags", 32'({CE_OUT, PERR, FERR, BUSY}), 32'd0);
    chk("arst_errcnt", 32'(ERRCNT), 32'd0);
    CLRN = 1'b1;
    err_m = '0;
    last_m = '0;
    tick();
    chk("post_rst_idle", 32'({CE_OUT, BUSY}), 32'd0);
    frame(4'b0001, 1'b1, 0, 1'b0);
    for (int n = 0; n < 300; n++) frame(4'b0000, 1'b1, 0, 1'b0);
    frame(4'b1001, 1'b0, 0, 1'b0);
    chk("b2b_ce_now", 32'(CE_OUT), 32'd1);
    chk("sat_errcnt", 32'(ERRCNT), 32'd255);
    repeat (3) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
